aes_uart_stream_ctrl: RTL and testbench

AES_UART_STREAM_CTRL -- requirements
Module: aes_uart_stream_ctrl

---
 rtl/aes_uart_pkg.sv | 24 ++
 rtl/uart_byte_sequencer.sv | 101 ++++++++++
 rtl/aes_uart_stream_ctrl.sv | 164 ++++++++++++++++
 tb/tb_aes_uart_stream_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_uart_pkg.sv
// Shared types and constants for the AES-over-UART stream controller.
// No logic, no latency, no flow control of its own.
package aes_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_RX_KEY,
        ST_RX_BLK,
        ST_CORE,
        ST_TX_BYTE,
        ST_TX_WAIT,
        ST_TX_GAP
    } state_t;

    localparam logic [7:0] CMD_KEY = 8'h4B;
    localparam logic [7:0] CMD_ENC = 8'h45;
    localparam logic [7:0] CMD_DEC = 8'h44;

    localparam int DEF_N          = 128;
    localparam int DEF_RX_TIMEOUT = 100000;
    localparam int DEF_TX_GAP     = 1000;

endpackage

// File: rtl/uart_byte_sequencer.sv
// Streams NB result bytes (byte 0 first) to a UART transmitter via tx_start/tx_ready handshake.
// First tx_start one cycle after i_start; TX_GAP idle cycles after each byte; stalls while tx_ready is low.
module uart_byte_sequencer
    import aes_uart_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int TX_GAP = DEF_TX_GAP
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clear,
    input  logic         i_start,
    input  logic [N-1:0] i_result,
    input  logic         i_tx_ready,
    output logic [7:0]   o_tx_data,
    output logic         o_tx_start,
    output logic         o_done
);

    localparam int NB = N / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam int GW = (TX_GAP > 1) ? $clog2(TX_GAP + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TX_GAP - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [GW-1:0] r_gap;
    logic          r_ready_d;
    logic [7:0]    r_tx_data;
    logic          r_tx_start;
    logic          r_done;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_gap      <= '0;
            r_ready_d  <= 1'b0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_ready_d <= i_tx_ready;
            r_done    <= 1'b0;
            if (i_clear) begin
                r_state    <= ST_IDLE;
                r_cnt      <= '0;
                r_gap      <= '0;
                r_tx_start <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            r_state <= ST_TX_BYTE;
                            r_cnt   <= '0;
                        end
                    end
                    ST_TX_BYTE: begin
                        // Request is held until the transmitter acknowledges by dropping ready.
                        if (!r_tx_start) begin
                            if (i_tx_ready) begin
                                r_tx_data  <= i_result[8*r_cnt +: 8];
                                r_tx_start <= 1'b1;
                            end
                        end else if (!i_tx_ready) begin
                            r_tx_start <= 1'b0;
                            r_state    <= ST_TX_WAIT;
                        end
                    end
                    ST_TX_WAIT: begin
                        if (i_tx_ready && !r_ready_d) begin
                            r_state <= ST_TX_GAP;
                            r_gap   <= '0;
                        end
                    end
                    ST_TX_GAP: begin
                        if (r_gap == GAP_LAST) begin
                            r_gap <= '0;
                            if (r_cnt == CNT_LAST) begin
                                r_done  <= 1'b1;
                                r_state <= ST_IDLE;
                            end else begin
                                r_cnt   <= r_cnt + 1'b1;
                                r_state <= ST_TX_BYTE;
                            end
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_done     = r_done;

endmodule

// File: rtl/aes_uart_stream_ctrl.sv
// UART command front-end for an AES core: 'K' key+block, 'E'/'D' block, result streamed back byte 0 first.
// Core started the cycle after the last rx byte; rx bytes arriving outside CMD/RX states are dropped.
module aes_uart_stream_ctrl
    import aes_uart_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int RX_TIMEOUT = DEF_RX_TIMEOUT,
    parameter int TX_GAP     = DEF_TX_GAP
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_enable,
    input  logic [7:0]   i_rx_data,
    input  logic         i_rx_valid,
    output logic [7:0]   o_tx_data,
    output logic         o_tx_start,
    input  logic         i_tx_ready,
    output logic [N-1:0] o_core_key,
    output logic [N-1:0] o_core_block,
    output logic         o_core_decrypt,
    output logic         o_core_start,
    input  logic         i_core_done,
    input  logic [N-1:0] i_core_result,
    output logic         o_key_valid,
    output logic         o_busy,
    output logic         o_err_timeout,
    output logic         o_err_cmd
);

    localparam int NB = N / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam int IW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(NB - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(RX_TIMEOUT - 1);

    state_t        r_state;
    logic [CW-1:0] r_byte_cnt;
    logic [IW-1:0] r_idle_cnt;
    logic          r_rx_valid_d;
    logic [N-1:0]  r_key;
    logic [N-1:0]  r_block;
    logic [N-1:0]  r_result;
    logic          r_decrypt;
    logic          r_key_valid;
    logic          r_core_start;
    logic          r_err_timeout;
    logic          r_err_cmd;

    logic          w_rx_rise;
    logic          w_seq_start;
    logic          w_seq_done;

    assign w_rx_rise   = i_rx_valid & ~r_rx_valid_d;
    assign w_seq_start = (r_state == ST_CORE) & i_core_done & i_enable;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_byte_cnt    <= '0;
            r_idle_cnt    <= '0;
            r_rx_valid_d  <= 1'b0;
            r_key         <= '0;
            r_block       <= '0;
            r_result      <= '0;
            r_decrypt     <= 1'b0;
            r_key_valid   <= 1'b0;
            r_core_start  <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_cmd     <= 1'b0;
        end else begin
            r_rx_valid_d  <= i_rx_valid;
            r_core_start  <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_cmd     <= 1'b0;
            if (!i_enable) begin
                r_state    <= ST_IDLE;
                r_byte_cnt <= '0;
                r_idle_cnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_CMD;
                    ST_CMD: begin
                        if (w_rx_rise) begin
                            r_byte_cnt <= '0;
                            r_idle_cnt <= '0;
                            if (i_rx_data == CMD_KEY) begin
                                r_decrypt <= 1'b0;
                                r_state   <= ST_RX_KEY;
                            end else if (((i_rx_data == CMD_ENC) || (i_rx_data == CMD_DEC)) && r_key_valid) begin
                                r_decrypt <= (i_rx_data == CMD_DEC);
                                r_state   <= ST_RX_BLK;
                            end else begin
                                r_err_cmd <= 1'b1;
                            end
                        end
                    end
                    ST_RX_KEY, ST_RX_BLK: begin
                        // A byte landing on the expiry cycle is taken and the timeout is skipped.
                        if (w_rx_rise) begin
                            r_idle_cnt <= '0;
                            if (r_state == ST_RX_KEY) r_key[8*r_byte_cnt +: 8] <= i_rx_data;
                            else                      r_block[8*r_byte_cnt +: 8] <= i_rx_data;
                            if (r_byte_cnt == CNT_LAST) begin
                                r_byte_cnt <= '0;
                                if (r_state == ST_RX_KEY) begin
                                    r_key_valid <= 1'b1;
                                    r_state     <= ST_RX_BLK;
                                end else begin
                                    r_core_start <= 1'b1;
                                    r_state      <= ST_CORE;
                                end
                            end else begin
                                r_byte_cnt <= r_byte_cnt + 1'b1;
                            end
                        end else if (r_idle_cnt == IDLE_LAST) begin
                            r_err_timeout <= 1'b1;
                            r_byte_cnt    <= '0;
                            r_idle_cnt    <= '0;
                            r_state       <= ST_CMD;
                            if (r_state == ST_RX_KEY) r_key_valid <= 1'b0;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                    end
                    ST_CORE: begin
                        if (i_core_done) begin
                            r_result <= i_core_result;
                            r_state  <= ST_TX_BYTE;
                        end
                    end
                    ST_TX_BYTE, ST_TX_WAIT, ST_TX_GAP: begin
                        if (w_seq_done) r_state <= ST_CMD;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    uart_byte_sequencer #(
        .N      (N),
        .TX_GAP (TX_GAP)
    ) u_seq (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (~i_enable),
        .i_start    (w_seq_start),
        .i_result   (r_result),
        .i_tx_ready (i_tx_ready),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .o_done     (w_seq_done)
    );

    assign o_core_key     = r_key;
    assign o_core_block   = r_block;
    assign o_core_decrypt = r_decrypt;
    assign o_core_start   = r_core_start;
    assign o_key_valid    = r_key_valid;
    assign o_busy         = (r_state != ST_IDLE) && (r_state != ST_CMD);
    assign o_err_timeout  = r_err_timeout;
    assign o_err_cmd      = r_err_cmd;

endmodule

// File: tb/tb_aes_uart_stream_ctrl.sv
// Directed bench for aes_uart_stream_ctrl using the FIPS-197 AES-128 example vector.
// Fields are byte-0-at-LSB, so hex constants below are the wire byte order reversed.
module tb_aes_uart_stream_ctrl;

    localparam int N   = 128;
    localparam int RXT = 50;
    localparam int GAP = 4;

    localparam logic [127:0] KEY = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] PT  = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic [7:0]   rx_data = '0;
    logic         rx_valid = 1'b0;
    logic [7:0]   tx_data;
    logic         tx_start;
    logic         tx_ready = 1'b1;
    logic [N-1:0] core_key;
    logic [N-1:0] core_block;
    logic         core_decrypt;
    logic         core_start;
    logic         core_done = 1'b0;
    logic [N-1:0] core_result = '0;
    logic         key_valid;
    logic         busy;
    logic         err_timeout;
    logic         err_cmd;

    int n_checks = 0;
    int n_errors = 0;
    int n_core_start = 0;
    int n_err_cmd = 0;
    int n_err_to = 0;

    aes_uart_stream_ctrl #(.N(N), .RX_TIMEOUT(RXT), .TX_GAP(GAP)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_enable       (enable),
        .i_rx_data      (rx_data),
        .i_rx_valid     (rx_valid),
        .o_tx_data      (tx_data),
        .o_tx_start     (tx_start),
        .i_tx_ready     (tx_ready),
        .o_core_key     (core_key),
        .o_core_block   (core_block),
        .o_core_decrypt (core_decrypt),
        .o_core_start   (core_start),
        .i_core_done    (core_done),
        .i_core_result  (core_result),
        .o_key_valid    (key_valid),
        .o_busy         (busy),
        .o_err_timeout  (err_timeout),
        .o_err_cmd      (err_cmd)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (core_start)  n_core_start++;
        if (err_cmd)     n_err_cmd++;
        if (err_timeout) n_err_to++;
    end

    // Stand-in for the AES core: knows only the FIPS-197 example pair.
    function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] b, input logic d);
        if (k == KEY && !d && b == PT) return CT;
        if (k == KEY &&  d && b == CT) return PT;
        return '0;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1 rx_data = b;
        rx_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 rx_valid = 1'b0;
        tick();
    endtask

    task automatic send_field(input logic [127:0] f);
        for (int i = 0; i < N / 8; i++) send_byte(f[8*i +: 8]);
    endtask

    task automatic core_respond(input logic d, input logic [127:0] k, input logic [127:0] b);
        check("core_decrypt", 128'(core_decrypt), 128'(d));
        check("core_key", core_key, k);
        check("core_block", core_block, b);
        check("busy in core", 128'(busy), 128'(1));
        repeat (3) tick();
        core_result = aes_model(core_key, core_block, core_decrypt);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        core_result = '0;
        check("core_key hold", core_key, k);
    endtask

    task automatic recv_byte(input logic [7:0] exp, input int idx, input logic drop_en);
        int  n;
        logic seen;
        n = 0;
        seen = 1'b0;
        while (n < 200 && !seen) begin
            tick();
            n++;
            if (tx_start) seen = 1'b1;
        end
        check($sformatf("tx_start seen[%0d]", idx), 128'(seen), 128'(1));
        if (seen) begin
            check($sformatf("tx_data[%0d]", idx), 128'(tx_data), 128'(exp));
            // ready rise -> TX_GAP entry, GAP counted cycles, back to TX_BYTE, then tx_start.
            if (idx > 0) check($sformatf("tx gap[%0d]", idx), 128'(n), 128'(GAP + 2));
            if (drop_en) begin
                enable = 1'b0;
                tick();
                check("tx_start after disable", 128'(tx_start), 128'(0));
                check("busy after disable", 128'(busy), 128'(0));
                check("key_valid after disable", 128'(key_valid), 128'(1));
            end else begin
                tick();
                tick();
                tx_ready = 1'b0;
                tick();
                check($sformatf("tx_start drop[%0d]", idx), 128'(tx_start), 128'(0));
                repeat (3) tick();
                tx_ready = 1'b1;
            end
        end
    endtask

    initial begin
        logic [127:0] f;
        int base;

        repeat (3) tick();
        check("rst busy", 128'(busy), 128'(0));
        check("rst tx_start", 128'(tx_start), 128'(0));
        check("rst tx_data", 128'(tx_data), 128'(0));
        check("rst core_start", 128'(core_start), 128'(0));
        check("rst core_decrypt", 128'(core_decrypt), 128'(0));
        check("rst key_valid", 128'(key_valid), 128'(0));
        check("rst err_cmd", 128'(err_cmd), 128'(0));
        check("rst err_timeout", 128'(err_timeout), 128'(0));
        check("rst core_key", core_key, 128'(0));
        check("rst core_block", core_block, 128'(0));
        reset = 1'b0;
        tick();
        enable = 1'b1;
        repeat (2) tick();

        // Bad commands: 'E' with no key, then an unknown byte.
        send_byte(8'h45);
        check("err_cmd on E w/o key", 128'(n_err_cmd), 128'(1));
        check("no core_start on E", 128'(n_core_start), 128'(0));
        check("busy after bad E", 128'(busy), 128'(0));
        send_byte(8'h58);
        check("err_cmd on 0x58", 128'(n_err_cmd), 128'(2));

        // 'K' + key + block -> encrypt.
        send_byte(8'h4B);
        check("busy in RX_KEY", 128'(busy), 128'(1));
        send_field(KEY);
        check("key_valid after key", 128'(key_valid), 128'(1));
        send_field(PT);
        check("core_start once (K)", 128'(n_core_start), 128'(1));
        core_respond(1'b0, KEY, PT);
        f = CT;
        for (int i = 0; i < 16; i++) recv_byte(f[8*i +: 8], i, 1'b0);
        repeat (GAP + 3) tick();
        check("busy after enc", 128'(busy), 128'(0));

        // 'D' reuses the stored key.
        send_byte(8'h44);
        send_field(CT);
        check("core_start once (D)", 128'(n_core_start), 128'(2));
        core_respond(1'b1, KEY, CT);
        f = PT;
        for (int i = 0; i < 16; i++) recv_byte(f[8*i +: 8], i, 1'b0);
        repeat (GAP + 3) tick();

        // Disable during third transmitted byte.
        send_byte(8'h45);
        send_field(PT);
        check("core_start once (E)", 128'(n_core_start), 128'(3));
        core_respond(1'b0, KEY, PT);
        f = CT;
        for (int i = 0; i < 3; i++) recv_byte(f[8*i +: 8], i, (i == 2));
        repeat (5) tick();
        check("tx_start stays low disabled", 128'(tx_start), 128'(0));
        enable = 1'b1;
        repeat (2) tick();
        check("no spurious err_cmd", 128'(n_err_cmd), 128'(2));

        // Key timeout: fifth byte lands exactly on the expiry cycle, then silence.
        send_byte(8'h4B);
        f = KEY;
        for (int i = 0; i < 4; i++) send_byte(f[8*i +: 8]);
        repeat (RXT - 4) @(posedge clk);
        send_byte(f[39:32]);
        check("byte wins over timeout", 128'(n_err_to), 128'(0));
        check("busy after boundary byte", 128'(busy), 128'(1));
        repeat (RXT - 3) tick();
        check("no timeout one early", 128'(err_timeout), 128'(0));
        tick();
        check("err_timeout pulse", 128'(err_timeout), 128'(1));
        check("key_valid cleared", 128'(key_valid), 128'(0));
        check("busy after timeout", 128'(busy), 128'(0));
        tick();
        check("err_timeout one cycle", 128'(n_err_to), 128'(1));

        // Reset while the core is busy; a late core_done must be ignored.
        send_byte(8'h4B);
        send_field(KEY);
        send_field(PT);
        check("core_start once (K2)", 128'(n_core_start), 128'(4));
        check("busy in CORE", 128'(busy), 128'(1));
        #3 reset = 1'b1;
        #1;
        check("async rst busy", 128'(busy), 128'(0));
        check("async rst key_valid", 128'(key_valid), 128'(0));
        check("async rst core_key", core_key, 128'(0));
        check("async rst core_block", core_block, 128'(0));
        check("async rst tx_data", 128'(tx_data), 128'(0));
        check("async rst tx_start", 128'(tx_start), 128'(0));
        repeat (2) tick();
        reset = 1'b0;
        tick();
        core_result = CT;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        core_result = '0;
        begin
            logic any_tx;
            any_tx = 1'b0;
            for (int i = 0; i < 30; i++) begin
                tick();
                if (tx_start || busy) any_tx = 1'b1;
            end
            check("late core_done ignored", 128'(any_tx), 128'(0));
        end
        check("post-rst core_key", core_key, 128'(0));
        check("post-rst core_decrypt", 128'(core_decrypt), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
